// File: rtl/face_transform_pkg.sv
// Shared face/matrix types, transform FSM states and the Q8.8 multiply helper
// used by the face transform stage.
package face_transform_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } Vertex_t;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] j;
        logic [15:0] k;
    } Vector_t;

    typedef struct packed {
        Vertex_t     v1;
        Vertex_t     v2;
        Vertex_t     v3;
        Vector_t     normal;
        logic [11:0] color;
    } Face_t;

    typedef struct packed {
        Vector_t v1;
        Vector_t v2;
        Vector_t v3;
    } Matrix_t;

    typedef enum logic [1:0] {IDLE, XFORM, DONE} XformState_t;

    localparam int XFORM_STEPS_MAX = 4;
    localparam int FACE_W          = $bits(Face_t);
    localparam int MATRIX_W        = $bits(Matrix_t);

    // Sign-magnitude multiply: truncating the magnitude rounds toward zero.
    function automatic logic [15:0] q8_8_mult(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] ma;
        logic [15:0] mb;
        logic [15:0] t;
        ma = a[15] ? (~a + 16'd1) : a;
        mb = b[15] ? (~b + 16'd1) : b;
        t  = 16'((32'(ma) * 32'(mb)) >> 8);
        return (a[15] ^ b[15]) ? (~t + 16'd1) : t;
    endfunction

endpackage

// File: rtl/face_transform_dot.sv
// Three-term Q8.8 dot product; the sum wraps modulo 2^16.
module DotProduct
    import face_transform_pkg::*;
(
    input  logic [15:0] a0_i,
    input  logic [15:0] a1_i,
    input  logic [15:0] a2_i,
    input  logic [15:0] b0_i,
    input  logic [15:0] b1_i,
    input  logic [15:0] b2_i,
    output logic [15:0] dot_o
);

    assign dot_o = q8_8_mult(a0_i, b0_i) + q8_8_mult(a1_i, b1_i) + q8_8_mult(a2_i, b2_i);

endmodule

// File: rtl/face_transform.sv
// Face transform stage: latches a face and a 3x3 Q8.8 matrix, then produces one
// transformed element (v1, v2, v3, optionally the normal) per cycle.
module face_transform
    import face_transform_pkg::*;
#(
    parameter bit XFORM_NORMAL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FACE_W-1:0]   in_face,
    input  logic [MATRIX_W-1:0] in_matrix,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FACE_W-1:0]   out_face,
    output logic                busy
);

    localparam logic [1:0] LAST = XFORM_NORMAL ? 2'd3 : 2'd2;

    XformState_t      state_q;
    logic [1:0]       idx_q;
    logic [3:0][47:0] vtx_q;
    Matrix_t          mat_q;
    Face_t            out_q;
    logic             out_valid_q;
    logic             busy_q;

    Face_t            in_f;
    Matrix_t          in_m;
    logic [15:0]      p0, p1, p2;
    logic [15:0]      rx, ry, rz;
    logic             accept;

    assign in_f      = in_face;
    assign in_m      = in_matrix;
    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_face  = out_q;

    // Element idx: 0=v1, 1=v2, 2=v3, 3=normal.
    assign {p0, p1, p2} = vtx_q[idx_q];

    DotProduct u_dot_x (.a0_i(p0), .a1_i(p1), .a2_i(p2),
                        .b0_i(mat_q.v1.i), .b1_i(mat_q.v1.j), .b2_i(mat_q.v1.k), .dot_o(rx));
    DotProduct u_dot_y (.a0_i(p0), .a1_i(p1), .a2_i(p2),
                        .b0_i(mat_q.v2.i), .b1_i(mat_q.v2.j), .b2_i(mat_q.v2.k), .dot_o(ry));
    DotProduct u_dot_z (.a0_i(p0), .a1_i(p1), .a2_i(p2),
                        .b0_i(mat_q.v3.i), .b1_i(mat_q.v3.j), .b2_i(mat_q.v3.k), .dot_o(rz));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            vtx_q       <= '0;
            mat_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        vtx_q       <= {in_f.normal, in_f.v3, in_f.v2, in_f.v1};
                        mat_q       <= in_m;
                        idx_q       <= '0;
                        out_q.color <= in_f.color;
                        if (!XFORM_NORMAL)
                            out_q.normal <= in_f.normal;
                        state_q     <= XFORM;
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else if (state_q == DONE && out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                XFORM: begin
                    case (idx_q)
                        2'd0:    out_q.v1 <= {rx, ry, rz};
                        2'd1:    out_q.v2 <= {rx, ry, rz};
                        2'd2:    out_q.v3 <= {rx, ry, rz};
                        default: if (XFORM_NORMAL) out_q.normal <= {rx, ry, rz};
                    endcase
                    if (idx_q == LAST) begin
                        state_q     <= DONE;
                        idx_q       <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_face_transform.sv
// Bench for face_transform: directed cases plus randomized back-to-back traffic,
// checked against an integer-arithmetic reference model.
module tb_face_transform;
    import face_transform_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic sel = 1'b0;
    Face_t   in_f;
    Matrix_t in_m;

    logic iv0, iv1, in_ready0, in_ready1, ov0, ov1, busy0, busy1;
    logic [FACE_W-1:0] of0, of1;
    logic in_ready, out_valid, busy;
    logic [FACE_W-1:0] out_face;
    Face_t ofs;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign iv0 = in_valid & ~sel;
    assign iv1 = in_valid & sel;
    assign in_ready  = sel ? in_ready1 : in_ready0;
    assign out_valid = sel ? ov1 : ov0;
    assign busy      = sel ? busy1 : busy0;
    assign out_face  = sel ? of1 : of0;
    assign ofs       = out_face;

    face_transform #(.XFORM_NORMAL(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(in_ready0), .in_face(in_f),
        .in_matrix(in_m), .out_valid(ov0), .out_ready(out_ready), .out_face(of0), .busy(busy0));

    face_transform #(.XFORM_NORMAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(in_ready1), .in_face(in_f),
        .in_matrix(in_m), .out_valid(ov1), .out_ready(out_ready), .out_face(of1), .busy(busy1));

    // Reference: real-valued product truncated toward zero, everything mod 2^16.
    function automatic logic [15:0] qm(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return 16'(p / 256);
    endfunction

    function automatic logic [47:0] xf(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input Matrix_t m);
        logic [15:0] x, y, z;
        x = qm(a, m.v1.i) + qm(b, m.v1.j) + qm(c, m.v1.k);
        y = qm(a, m.v2.i) + qm(b, m.v2.j) + qm(c, m.v2.k);
        z = qm(a, m.v3.i) + qm(b, m.v3.j) + qm(c, m.v3.k);
        return {x, y, z};
    endfunction

    function automatic Face_t model(input Face_t f, input Matrix_t m, input bit xn);
        Face_t r;
        r    = f;
        r.v1 = xf(f.v1.x, f.v1.y, f.v1.z, m);
        r.v2 = xf(f.v2.x, f.v2.y, f.v2.z, m);
        r.v3 = xf(f.v3.x, f.v3.y, f.v3.z, m);
        if (xn) r.normal = xf(f.normal.i, f.normal.j, f.normal.k, m);
        return r;
    endfunction

    function automatic Face_t rface();
        logic [FACE_W-1:0] b;
        for (int i = 0; i < FACE_W; i++) b[i] = 1'($urandom);
        return b;
    endfunction

    function automatic Matrix_t rmat();
        logic [MATRIX_W-1:0] b;
        for (int i = 0; i < MATRIX_W; i++) b[i] = 1'($urandom);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a face, wait (bounded) for in_ready, return at the negedge after the accept edge.
    task automatic send(input Face_t f, input Matrix_t m);
        int n;
        n = 0;
        in_f = f; in_m = m; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 30) begin tick(); #1; n++; end
        chk("send_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drain_ov", out_valid, 0);
    endtask

    task automatic b2b(input int nf, input int period, input bit xn);
        Face_t q[$];
        Face_t cur, e;
        Matrix_t cm;
        int acc, got, last, cyc;
        bit pend;
        acc = 0; got = 0; last = -1; cyc = 0; pend = 0;
        out_ready = 1'b1;
        cur = rface(); cm = rmat();
        if (!xn) cur.normal = '{16'h1234, 16'h5678, 16'h9ABC};
        in_f = cur; in_m = cm; in_valid = 1'b1;
        while (got < nf && cyc < 200) begin
            #1;
            if (out_valid) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                chk("b2b_face", out_face, e);
                if (last >= 0) chk("b2b_period", cyc - last, period);
                last = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(cur, cm, xn));
                acc++;
                pend = 1'b1;
            end
            tick();
            cyc++;
            if (pend) begin
                pend = 1'b0;
                if (acc < nf) begin
                    cur = rface(); cm = rmat();
                    if (!xn) cur.normal = '{16'h1234, 16'h5678, 16'h9ABC};
                    in_f = cur; in_m = cm;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_count", got, nf);
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Face_t f, f2;
        Matrix_t m, idm;
        int lat;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_ov", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_face", out_face, 0);
        rst = 1'b0;
        tick();

        // Identity: output equals input exactly
        idm = '{'{16'h0100, 16'h0, 16'h0}, '{16'h0, 16'h0100, 16'h0}, '{16'h0, 16'h0, 16'h0100}};
        f.v1 = '{16'h0200, 16'h0300, 16'h0400};
        f.v2 = '{16'hFF00, 16'h0000, 16'h0080};
        f.v3 = '0;
        f.normal = '{16'h0, 16'h0, 16'h0100};
        f.color = 12'hABC;
        send(f, idm);
        chk("id_busy", busy, 1);
        chk("id_ov_early", out_valid, 0);
        wait_out(lat);
        chk("id_latency", lat, 4);
        chk("id_face", out_face, f);
        chk("done_ready_low", in_ready, 0);
        drain();

        // Scale/negate with a truncation case
        m = '{'{16'h0200, 16'h0, 16'h0}, '{16'h0, 16'hFF00, 16'h0}, '{16'h0, 16'h0, 16'h0080}};
        f = rface();
        f.v1 = '{16'h0300, 16'h0200, 16'h0400};
        f.v2 = '{16'h0, 16'h0, 16'h0001};
        send(f, m);
        wait_out(lat);
        chk("scale_v1", ofs.v1, 48'h0600_FE00_0200);
        chk("scale_trunc", ofs.v2.z, 16'h0000);
        chk("scale_face", out_face, model(f, m, 1'b1));
        drain();

        // Rotation/swap
        m = '{'{16'h0, 16'h0100, 16'h0}, '{16'h0100, 16'h0, 16'h0}, '{16'h0, 16'h0, 16'h0100}};
        f = rface();
        f.v1 = '{16'h0100, 16'h0200, 16'h0300};
        send(f, m);
        wait_out(lat);
        chk("rot_v1", ofs.v1, 48'h0200_0100_0300);
        chk("rot_face", out_face, model(f, m, 1'b1));
        drain();

        // Wrap: 0x7F00 * 2.0 wraps to 0xFE00
        m = '{'{16'h0200, 16'h0, 16'h0}, '{16'h0, 16'h0200, 16'h0}, '{16'h0, 16'h0, 16'h0200}};
        f = rface();
        f.v1 = '{16'h7F00, 16'h0, 16'h0};
        send(f, m);
        wait_out(lat);
        chk("wrap_x", ofs.v1.x, 16'hFE00);
        chk("wrap_face", out_face, model(f, m, 1'b1));
        drain();

        // Backpressure then same-edge handoff
        f = rface(); m = rmat();
        send(f, m);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            chk("bp_face", out_face, model(f, m, 1'b1));
            chk("bp_ov", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            tick();
        end
        f2 = rface(); m = rmat();
        in_f = f2; in_m = m; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("handoff_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("handoff_busy", busy, 1);
        chk("handoff_ov", out_valid, 0);
        wait_out(lat);
        chk("handoff_latency", lat, 4);
        chk("handoff_face", out_face, model(f2, m, 1'b1));
        drain();

        // Reset while idx==1, then a clean face
        f = rface(); m = rmat();
        send(f, m);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_ov", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 1);
        rst = 1'b0;
        f = rface(); m = rmat();
        send(f, m);
        wait_out(lat);
        chk("postrst_latency", lat, 4);
        chk("postrst_face", out_face, model(f, m, 1'b1));
        drain();

        // Back-to-back, normal transformed: one face every 5 cycles
        b2b(5, 5, 1'b1);

        // XFORM_NORMAL=0 instance: normal passes through, one face every 4 cycles
        sel = 1'b1;
        #1;
        chk("n0_ready", in_ready, 1);
        chk("n0_ov", out_valid, 0);
        f = rface(); m = rmat();
        f.normal = '{16'h1234, 16'h5678, 16'h9ABC};
        send(f, m);
        wait_out(lat);
        chk("n0_latency", lat, 3);
        chk("n0_normal", ofs.normal, 48'h1234_5678_9ABC);
        drain();
        b2b(5, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
